// File: rtl/serial_io_pkg.sv
// Shared constants for the serial IO transmit sequencer.
// Port bases, 16550 register offsets and FSM state codes.
package serial_io_pkg;

    localparam logic [11:0] PORT_RS232 = 12'h020;
    localparam logic [11:0] PORT_WIFI  = 12'h021;
    localparam logic [11:0] PORT_BT    = 12'h022;
    localparam logic [11:0] PORT_BT2   = 12'h023;

    localparam logic [3:0] REG_THR = 4'h0;
    localparam logic [3:0] REG_LSR = 4'hA;

    localparam int LSR_THRE_BIT = 5;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t IDLE    = 3'd0;
    localparam tx_state_t LSR_RD  = 3'd1;
    localparam tx_state_t LSR_CHK = 3'd2;
    localparam tx_state_t THR_WR  = 3'd3;
    localparam tx_state_t RECOVER = 3'd4;

    function automatic logic [15:0] io_addr(
        input logic [1:0] port,
        input logic [3:0] ofs
    );
        logic [11:0] base;
        unique case (port)
            2'd0:    base = PORT_RS232;
            2'd1:    base = PORT_WIFI;
            2'd2:    base = PORT_BT;
            default: base = PORT_BT2;
        endcase
        return {base, ofs};
    endfunction

endpackage

// File: rtl/serial_io_access_timer.sv
// Bus access timer: reloads to zero, counts up, flags the final
// cycle of an ACCESS_CYCLES-long access.
module serial_io_access_timer #(
    parameter int ACCESS_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic last
);

    localparam int CW = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST_CNT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_io_tx_sequencer.sv
// Polls a 16550 LSR until THRE, then writes the byte to THR.
// SERIAL_IO_POLL_TIMEOUT_EN enables the poll-limit abort.
module serial_io_tx_sequencer #(
    parameter int ACCESS_CYCLES = 4,
    parameter int POLL_LIMIT    = 1024
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic [7:0]  TxData,
    input  logic [1:0]  TxPort,
    input  logic        TxValid,
    output logic        TxReady,
    output logic        TxDone,
    output logic        TxError,
    output logic [15:0] Address,
    output logic        IOSelect_H,
    output logic        ByteSelect_L,
    output logic        WE_L,
    output logic [7:0]  DataOut,
    input  logic [7:0]  DataIn
);

    import serial_io_pkg::*;

    if (ACCESS_CYCLES < 2) begin : g_bad_access
        $error("ACCESS_CYCLES must be >= 2");
    end
    if (POLL_LIMIT < 1) begin : g_bad_poll
        $error("POLL_LIMIT must be >= 1");
    end

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [7:0]  data_q;
    logic [1:0]  port_q;
    logic [1:0]  port_d;
    logic        thre_q;
    logic        last;
    logic        accept;
    logic        poll_stop;
    logic        err_d;
    logic        bus_on;
    logic        lsr_unused;

    assign accept = (state_q == IDLE) && TxValid && TxReady;
    assign port_d = accept ? TxPort : port_q;
    assign lsr_unused = ^DataIn;

`ifdef SERIAL_IO_POLL_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_LIMIT);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    logic [PW-1:0] poll_q;

    always_ff @(posedge Clock) begin
        if (!Reset_L) begin
            poll_q <= '0;
        end else if (accept) begin
            poll_q <= '0;
        end else if (state_q == LSR_CHK && !thre_q && poll_q != POLL_MAX) begin
            poll_q <= poll_q + 1'b1;
        end
    end

    assign poll_stop = (poll_q == POLL_LAST);
    // Raised while LSR_CHK is occupied, i.e. decided on the final read edge
    assign err_d = (state_q == LSR_RD) && last
                && !DataIn[LSR_THRE_BIT] && poll_stop;
`else
    assign poll_stop = 1'b0;
    assign err_d     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LSR_RD;
            LSR_RD:  if (last) state_d = LSR_CHK;
            LSR_CHK: begin
                if (thre_q)         state_d = THR_WR;
                else if (poll_stop) state_d = IDLE;
                else                state_d = LSR_RD;
            end
            THR_WR:  if (last) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    serial_io_access_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk  (Clock),
        .rst_n(Reset_L),
        .load (state_d != state_q),
        .last (last)
    );

    assign bus_on = (state_d == LSR_RD) || (state_d == THR_WR);

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge Clock) begin
        if (!Reset_L) begin
            state_q      <= IDLE;
            data_q       <= '0;
            port_q       <= '0;
            thre_q       <= 1'b0;
            TxReady      <= 1'b0;
            TxDone       <= 1'b0;
            TxError      <= 1'b0;
            Address      <= '0;
            IOSelect_H   <= 1'b0;
            ByteSelect_L <= 1'b1;
            WE_L         <= 1'b1;
            DataOut      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= TxData;
                port_q <= TxPort;
            end
            if (state_q == LSR_RD && last) begin
                thre_q <= DataIn[LSR_THRE_BIT];
            end
            TxReady      <= (state_d == IDLE);
            TxDone       <= (state_d == RECOVER);
            TxError      <= err_d;
            IOSelect_H   <= bus_on;
            ByteSelect_L <= !bus_on;
            WE_L         <= (state_d != THR_WR);
            DataOut      <= (state_d == THR_WR) ? data_q : 8'h00;
            if (state_d == LSR_RD) begin
                Address <= io_addr(port_d, REG_LSR);
            end else if (state_d == THR_WR) begin
                Address <= io_addr(port_q, REG_THR);
            end else begin
                Address <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_serial_io_tx_sequencer.sv
// Self-checking bench for serial_io_tx_sequencer: transaction-level
// expected bus trace plus directed literal checks.
module tb_serial_io_tx_sequencer;

    localparam int AC = 4;
    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [7:0]  tx_data;
    logic [1:0]  tx_port;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_error;
    logic [15:0] address;
    logic        io_sel;
    logic        byte_sel_l;
    logic        we_l;
    logic [7:0]  data_out;
    logic [7:0]  data_in = 8'hFF;

    always #5 clk = ~clk;

    serial_io_tx_sequencer #(
        .ACCESS_CYCLES(AC),
        .POLL_LIMIT   (PL)
    ) dut (
        .Clock       (clk),
        .Reset_L     (rst_l),
        .TxData      (tx_data),
        .TxPort      (tx_port),
        .TxValid     (tx_valid),
        .TxReady     (tx_ready),
        .TxDone      (tx_done),
        .TxError     (tx_error),
        .Address     (address),
        .IOSelect_H  (io_sel),
        .ByteSelect_L(byte_sel_l),
        .WE_L        (we_l),
        .DataOut     (data_out),
        .DataIn      (data_in)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        iosel;
        logic        bsel_l;
        logic        we_l;
        logic [7:0]  dout;
        logic        ready;
        logic        done;
        logic        err;
    } bus_t;

`ifdef SERIAL_IO_POLL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    bus_t        exp_q[$];
    bus_t        exp;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc[$];
    int          cfg_busy = 0;
    logic [7:0]  cfg_rdy = 8'h20;
    int          rsp_busy = 0;
    logic [7:0]  rsp_rdy = 8'h20;
    int          rd_cycles = 0;

    logic [15:0] rd_log[$];
    logic [15:0] wr_log[$];
    logic [7:0]  wd_log[$];
    int          done_cyc[$];
    int          rd_cyc_cnt = 0;
    int          wr_cyc_cnt = 0;
    int          err_cnt = 0;
    int          bsel_bad = 0;
    logic        prev_io = 1'b0;

    function automatic bus_t idle_bus(bit rdy, bit done, bit err);
        bus_t b;
        b.addr = 16'h0000; b.iosel = 1'b0; b.bsel_l = 1'b1;
        b.we_l = 1'b1; b.dout = 8'h00;
        b.ready = rdy; b.done = done; b.err = err;
        return b;
    endfunction

    function automatic bus_t acc_bus(logic [15:0] a, bit wr, logic [7:0] d);
        bus_t b;
        b.addr = a; b.iosel = 1'b1; b.bsel_l = 1'b0;
        b.we_l = !wr; b.dout = wr ? d : 8'h00;
        b.ready = 1'b0; b.done = 1'b0; b.err = 1'b0;
        return b;
    endfunction

    // One accepted byte expands into its whole expected bus trace
    function automatic void push_txn(logic [7:0] d, logic [1:0] p, int busy);
        logic [15:0] base;
        bit          to;
        int          polls;
        base  = 16'h0200 + {10'd0, p, 4'd0};
        to    = TIMEOUT_EN && (busy >= PL);
        polls = to ? PL : busy + 1;
        for (int i = 0; i < polls; i++) begin
            repeat (AC) exp_q.push_back(acc_bus(base + 16'h000A, 1'b0, 8'h00));
            exp_q.push_back(idle_bus(1'b0, 1'b0, to && (i == polls - 1)));
        end
        if (!to) begin
            repeat (AC) exp_q.push_back(acc_bus(base, 1'b1, d));
            exp_q.push_back(idle_bus(1'b0, 1'b1, 1'b0));
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_l) begin
            exp_q.delete();
            exp = idle_bus(1'b0, 1'b0, 1'b0);
        end else begin
            if (exp.ready && tx_valid) begin
                push_txn(tx_data, tx_port, cfg_busy);
                acc_cnt++;
                acc_cyc.push_back(cyc - 1);
                rsp_busy  = cfg_busy;
                rsp_rdy   = cfg_rdy;
                rd_cycles = 0;
            end
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else                  exp = idle_bus(1'b1, 1'b0, 1'b0);
        end
        chk_en = 1'b1;
    end

    // UART side: LSR reads answer "busy" for the first rsp_busy reads
    always @(negedge clk) begin
        if (io_sel === 1'b1 && we_l === 1'b1) begin
            data_in = ((rd_cycles / AC) < rsp_busy) ? 8'h00 : rsp_rdy;
            rd_cycles++;
        end else begin
            data_in = 8'hFF;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({address, io_sel, byte_sel_l, we_l, data_out,
                 tx_ready, tx_done, tx_error} !== exp) begin
                failures++;
                $display("FAIL bus cyc=%0d got a=%h io=%b bs=%b we=%b d=%h rdy=%b dn=%b er=%b want a=%h io=%b bs=%b we=%b d=%h rdy=%b dn=%b er=%b",
                         cyc, address, io_sel, byte_sel_l, we_l, data_out,
                         tx_ready, tx_done, tx_error, exp.addr, exp.iosel,
                         exp.bsel_l, exp.we_l, exp.dout, exp.ready,
                         exp.done, exp.err);
            end
            if (io_sel === 1'b1 && prev_io !== 1'b1) begin
                if (we_l === 1'b1) begin
                    rd_log.push_back(address);
                end else begin
                    wr_log.push_back(address);
                    wd_log.push_back(data_out);
                end
            end
            if (io_sel === 1'b1 && we_l === 1'b1) rd_cyc_cnt++;
            if (io_sel === 1'b1 && we_l === 1'b0) wr_cyc_cnt++;
            if (byte_sel_l === 1'b0 && io_sel !== 1'b1) bsel_bad++;
            if (tx_done === 1'b1) done_cyc.push_back(cyc);
            if (tx_error === 1'b1) err_cnt++;
            prev_io = io_sel;
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete(); wd_log.delete();
        done_cyc.delete(); acc_cyc.delete();
        rd_cyc_cnt = 0; wr_cyc_cnt = 0; err_cnt = 0; bsel_bad = 0;
    endtask

    task automatic wait_accept(string name);
        int n;
        int t;
        n = acc_cnt;
        t = 0;
        while (acc_cnt == n && t < 100) begin
            tick(1);
            t++;
        end
        check({name, "_accepted"}, acc_cnt - n, 1);
    endtask

    task automatic send(logic [7:0] d, logic [1:0] p, int busy, logic [7:0] rdy);
        cfg_busy = busy;
        cfg_rdy  = rdy;
        tx_data  = d;
        tx_port  = p;
        tx_valid = 1'b1;
        wait_accept("send");
        tx_valid = 1'b0;
        tx_data  = 8'hEE;
        tx_port  = ~p;
    endtask

    task automatic wait_idle(int limit);
        int t;
        t = 0;
        while ((exp_q.size() > 0 || exp.ready !== 1'b1) && t < limit) begin
            tick(1);
            t++;
        end
        check("idle_reached", t < limit, 1);
        tick(2);
    endtask

    initial begin
        rst_l    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_port  = 2'd0;
        tick(3);
        check("rst_ready", tx_ready, 0);
        check("rst_addr", address, 16'h0000);
        check("rst_iosel", io_sel, 0);
        check("rst_bsel", byte_sel_l, 1);
        check("rst_we", we_l, 1);
        rst_l = 1'b1;
        tick(1);
        check("ready_after_rst", tx_ready, 1);

        // Basic write on Wifi port
        clear_logs();
        send(8'h41, 2'd1, 0, 8'h20);
        wait_idle(200);
        check("t1_reads", rd_log.size(), 1);
        check("t1_rd_addr", rd_log[0], 16'h021A);
        check("t1_rd_cycles", rd_cyc_cnt, 4);
        check("t1_writes", wr_log.size(), 1);
        check("t1_wr_addr", wr_log[0], 16'h0210);
        check("t1_wr_data", wd_log[0], 8'h41);
        check("t1_wr_cycles", wr_cyc_cnt, 4);
        check("t1_dones", done_cyc.size(), 1);
        check("t1_done_offset", done_cyc[0] - acc_cyc[0], 10);

        // Busy UART on Bluetooth2
        clear_logs();
        send(8'h55, 2'd3, 3, 8'h60);
        wait_idle(300);
        check("t2_reads", rd_log.size(), 4);
        foreach (rd_log[i]) check("t2_rd_addr", rd_log[i], 16'h023A);
        check("t2_writes", wr_log.size(), 1);
        check("t2_wr_addr", wr_log[0], 16'h0230);
        check("t2_wr_data", wd_log[0], 8'h55);
        check("t2_dones", done_cyc.size(), 1);

        // Port sweep, TxValid held high
        clear_logs();
        cfg_busy = 0;
        cfg_rdy  = 8'h20;
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'h10 + 8'(i);
            tx_port = 2'(i);
            wait_accept("sweep");
        end
        tx_valid = 1'b0;
        wait_idle(300);
        check("t3_writes", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t3_wr_addr", wr_log[i], 16'h0200 + 16'(i * 16));
            check("t3_wr_data", wd_log[i], 8'h10 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            check("t3_spacing", acc_cyc[i + 1] - acc_cyc[i], 2 * AC + 3);
        end
        check("t3_bsel_only_with_iosel", bsel_bad, 0);

        // Reset on the second write cycle
        clear_logs();
        send(8'h77, 2'd2, 0, 8'h20);
        begin
            int t;
            t = 0;
            while (we_l !== 1'b0 && t < 50) begin
                tick(1);
                t++;
            end
            check("t4_write_seen", t < 50, 1);
        end
        tick(1);
        rst_l = 1'b0;
        tick(1);
        check("t4_iosel", io_sel, 0);
        check("t4_we", we_l, 1);
        rst_l = 1'b1;
        tick(1);
        check("t4_ready", tx_ready, 1);
        tick(3);
        check("t4_no_done", done_cyc.size(), 0);
        send(8'h78, 2'd2, 0, 8'h20);
        wait_idle(200);
        check("t4_next_done", done_cyc.size(), 1);
        check("t4_next_wr", wr_log[wr_log.size() - 1], 16'h0220);
        check("t4_next_data", wd_log[wd_log.size() - 1], 8'h78);

        // UART never ready within the poll limit
        clear_logs();
        send(8'h99, 2'd0, 110, 8'h20);
        wait_idle(1500);
`ifdef SERIAL_IO_POLL_TIMEOUT_EN
        check("t5_reads", rd_log.size(), PL);
        check("t5_errors", err_cnt, 1);
        check("t5_writes", wr_log.size(), 0);
        check("t5_dones", done_cyc.size(), 0);
`else
        check("t6_reads_ge_100", rd_log.size() >= 100, 1);
        check("t6_reads", rd_log.size(), 111);
        check("t6_errors", err_cnt, 0);
        check("t6_writes", wr_log.size(), 1);
`endif
        check("t5_ready_back", tx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
